axis_pkt_sum: RTL and testbench
===============================

Name: axis_pkt_sum

Overview:
- AXI-Stream packet reducer. It sits directly downstream of axis_fifo and consumes the FIFO's master stream, one packet at a time.
- Each packet is reduced to one summary word: the modulo-2^W sum of all its data beats.
- The summary is emitted as a single-beat packet on its own master stream, for the DMA/PS side to read back.
- Used to check FIFO store/forward integrity in hardware.

Parameters:
- C_S_AXIS_TDATA_WIDTH, 32, slave data width in bits; multiple of 8.
- C_M_AXIS_TDATA_WIDTH, 32, master data width in bits; must equal C_S_AXIS_TDATA_WIDTH.
- C_MAX_PKT_WORDS, 80, maximum beats per packet; a packet is force-terminated when it reaches this count.

Ports:
- axis_aclk  in  1  single clock for both streams.
- axis_areset  in  1  asynchronous reset, active-high.
- s00_axis_tdata  in  C_S_AXIS_TDATA_WIDTH  input data.
- s00_axis_tstrb  in  C_S_AXIS_TDATA_WIDTH/8  byte strobes; ignored unless STRB_MASK_EN.
- s00_axis_tlast  in  1  last beat of input packet.
- s00_axis_tvalid  in  1  input beat valid.
- s00_axis_tready  out  1  input beat accepted when high with tvalid.
- m00_axis_tdata  out  C_M_AXIS_TDATA_WIDTH  summary word.
- m00_axis_tstrb  out  C_M_AXIS_TDATA_WIDTH/8  constant all-ones.
- m00_axis_tlast  out  1  high on every output beat (single-beat packets).
- m00_axis_tvalid  out  1  summary valid.
- m00_axis_tready  in  1  downstream ready.
- pkt_overrun  out  1  sticky; set when a packet is force-terminated at C_MAX_PKT_WORDS without tlast.
- pkt_count  out  16  number of summaries delivered; wraps at 0xFFFF->0.

Behaviour:
- Reset (async, immediate): state=ACCUM, sum=0, beat count=0, s00_axis_tready=0 while reset is asserted, m00_axis_tvalid=0, m00_axis_tdata=0, m00_axis_tlast=0, pkt_overrun=0, pkt_count=0. Reset mid-packet discards the partial sum; no summary is emitted.
- s00_axis_tready = (state==ACCUM) and not in reset. It is a registered state decode, not combinationally dependent on tvalid.
- State ACCUM, on each accepted beat (tvalid&&tready):
  - sum <= sum + tdata, truncated to W bits (wrap-around, no carry out).
  - count <= count+1.
- End of packet, in ACCUM: when an accepted beat has tlast=1, or count==C_MAX_PKT_WORDS-1:
  - Load the output register with the final sum including this beat.
  - Assert m00_axis_tvalid; clear sum and count; go to SEND.
  - The first output is visible the cycle after the last input beat, so latency is 1 cycle.
- Forced end: a forced end without tlast sets pkt_overrun. Following beats start a new packet.
- State SEND:
  - s00_axis_tready=0.
  - m00_axis_tvalid, tdata and tlast are held stable until m00_axis_tready=1.
  - On that handshake: m00_axis_tvalid<=0, pkt_count++, state<=ACCUM. s00_axis_tready is high the following cycle.
- Throughput: a single-beat input packet costs a minimum of 2 cycles (accept, then send).
- tvalid without tready is never accepted. Input tlast is not sampled outside a handshake.
- Zero-length packets do not exist; every output summarizes at least 1 beat.

Optional Feature:
- Macro: AXIS_PKT_SUM_STRB_MASK_EN.
- Defined: each byte lane of s00_axis_tdata is zeroed where the corresponding s00_axis_tstrb bit is 0 before accumulation.
- Undefined: tstrb is ignored; full tdata is summed.
- Port list is identical in both builds.

Test Plan:
- Beats 1,2,3,4 (tlast on 4), m00_tready=1 -> one output beat, tdata=0x0000000A, tlast=1, pkt_count=1, pkt_overrun=0.
- Beats 0xFFFFFFFF, 0x00000002 (tlast) -> tdata=0x00000001 (wrap).
- 80 beats of 0x1, tlast never asserted -> tdata=0x50 after beat 80, pkt_overrun=1. A subsequent 1-beat packet 0x7 (tlast) -> tdata=0x7.
- Summary pending, m00_tready=0 for 5 cycles -> tvalid stays 1, tdata stable, s00_tready=0 throughout. Handshake on cycle 6 -> s00_tready=1 next cycle.
- Reset asserted after 3 of 5 beats, then packet 5,5 (tlast) -> only one output, tdata=0xA, pkt_count=1.
- Macro defined: beat 0xAABBCCDD with tstrb=4'b0101 (tlast) -> tdata=0x00BB00DD. Macro undefined -> tdata=0xAABBCCDD.

Source files
------------

// File: rtl/axis_pkt_sum.sv
// axis_pkt_sum: reduces each AXI-Stream input packet to one summary word
// (modulo-2^W sum of its beats) and emits it as a single-beat packet.
// Packets reaching C_MAX_PKT_WORDS beats without tlast are force-terminated
// and flagged through the sticky pkt_overrun output.
// Optional build macro: AXIS_PKT_SUM_STRB_MASK_EN -- when defined, byte lanes
// with tstrb=0 are zeroed before accumulation; otherwise tstrb is ignored.
module axis_pkt_sum #(
   parameter int C_S_AXIS_TDATA_WIDTH = 32,
   parameter int C_M_AXIS_TDATA_WIDTH = 32,
   parameter int C_MAX_PKT_WORDS      = 80
) (
   input  logic                              axis_aclk,
   input  logic                              axis_areset,
   input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
   input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
   input  logic                              s00_axis_tlast,
   input  logic                              s00_axis_tvalid,
   output logic                              s00_axis_tready,
   output logic [C_M_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
   output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
   output logic                              m00_axis_tlast,
   output logic                              m00_axis_tvalid,
   input  logic                              m00_axis_tready,
   output logic                              pkt_overrun,
   output logic [15:0]                       pkt_count
);

   localparam int W  = C_S_AXIS_TDATA_WIDTH;
   localparam int NB = W / 8;
   localparam int CW = $clog2(C_MAX_PKT_WORDS + 1);

   typedef enum logic {ACCUM, SEND} state_t;

   state_t         state, state_nxt;
   logic [W-1:0]   beat_data;
   logic [W-1:0]   sum;
   logic [W-1:0]   sum_nxt;
   logic [CW-1:0]  cnt;
   logic           s_hs, m_hs, forced, eop;

`ifdef AXIS_PKT_SUM_STRB_MASK_EN
   // Zero the byte lanes whose strobe is low before they reach the adder.
   always_comb begin
      beat_data = '0;
      for (int i = 0; i < NB; i++)
         beat_data[i*8 +: 8] = s00_axis_tstrb[i] ? s00_axis_tdata[i*8 +: 8] : 8'h00;
   end
`else
   logic strb_unused;
   assign strb_unused = ^s00_axis_tstrb;
   assign beat_data   = s00_axis_tdata;
`endif

   // Input is only open while accumulating; reset forces it closed immediately.
   assign s00_axis_tready = (state == ACCUM) && !axis_areset;
   assign s_hs    = s00_axis_tvalid && s00_axis_tready;
   assign m_hs    = m00_axis_tvalid && m00_axis_tready;
   assign forced  = (cnt == CW'(C_MAX_PKT_WORDS - 1));
   assign eop     = s_hs && (s00_axis_tlast || forced);
   assign sum_nxt = sum + beat_data;

   assign m00_axis_tstrb = '1;
   assign m00_axis_tlast = m00_axis_tvalid;

   // State register.
   always_ff @(posedge axis_aclk or posedge axis_areset) begin
      if (axis_areset) state <= ACCUM;
      else             state <= state_nxt;
   end

   // Next state: leave ACCUM at end of packet, leave SEND on output handshake.
   always_comb begin
      state_nxt = state;
      case (state)
         ACCUM: if (eop)             state_nxt = SEND;
         SEND:  if (m00_axis_tready) state_nxt = ACCUM;
         default:                    state_nxt = ACCUM;
      endcase
   end

   // Accumulator, beat counter, output register and status counters.
   always_ff @(posedge axis_aclk or posedge axis_areset) begin
      if (axis_areset) begin
         sum             <= '0;
         cnt             <= '0;
         m00_axis_tdata  <= '0;
         m00_axis_tvalid <= 1'b0;
         pkt_overrun     <= 1'b0;
         pkt_count       <= '0;
      end else begin
         if (s_hs) begin
            if (eop) begin
               sum             <= '0;
               cnt             <= '0;
               m00_axis_tdata  <= sum_nxt;
               m00_axis_tvalid <= 1'b1;
               if (!s00_axis_tlast) pkt_overrun <= 1'b1;
            end else begin
               sum <= sum_nxt;
               cnt <= cnt + 1'b1;
            end
         end
         if (m_hs) begin
            m00_axis_tvalid <= 1'b0;
            pkt_count       <= pkt_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_axis_pkt_sum.sv
// tb_axis_pkt_sum: directed and randomized checks of axis_pkt_sum against a
// stream-level reference model (list of accepted beats -> expected summaries).
module tb_axis_pkt_sum;

   localparam int MAXW = 80;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] s_tdata = '0;
   logic [3:0]  s_tstrb = '0;
   logic        s_tlast = 1'b0;
   logic        s_tvalid = 1'b0;
   logic        s_tready;
   logic [31:0] m_tdata;
   logic [3:0]  m_tstrb;
   logic        m_tlast;
   logic        m_tvalid;
   logic        m_tready = 1'b0;
   logic        ovr;
   logic [15:0] pcnt;

   always #5 clk = ~clk;

   axis_pkt_sum dut (
      .axis_aclk       (clk),
      .axis_areset     (rst),
      .s00_axis_tdata  (s_tdata),
      .s00_axis_tstrb  (s_tstrb),
      .s00_axis_tlast  (s_tlast),
      .s00_axis_tvalid (s_tvalid),
      .s00_axis_tready (s_tready),
      .m00_axis_tdata  (m_tdata),
      .m00_axis_tstrb  (m_tstrb),
      .m00_axis_tlast  (m_tlast),
      .m00_axis_tvalid (m_tvalid),
      .m00_axis_tready (m_tready),
      .pkt_overrun     (ovr),
      .pkt_count       (pcnt)
   );

   typedef struct {
      logic [31:0] d;
      logic [3:0]  s;
      logic        l;
   } beat_t;

   beat_t       stim_q[$];
   logic [31:0] exp_q[$];
   logic [31:0] pkt_beats[$];   // beats of the packet currently being reduced
   logic        exp_ovr;
   logic [15:0] delivered;
   int          n_out;
   logic [31:0] last_out;
   logic        s_pending, stalled;
   logic [31:0] held;
   int          n_tests = 0;
   int          n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] eff_data(input beat_t b);
      logic [31:0] r;
      r = b.d;
`ifdef AXIS_PKT_SUM_STRB_MASK_EN
      for (int i = 0; i < 4; i++)
         if (!b.s[i]) r[i*8 +: 8] = 8'h00;
`endif
      return r;
   endfunction

   // Reference: a packet closes on tlast or when it holds MAXW beats; its
   // summary is the plain sum of its beats modulo 2^32.
   task automatic model_beat(input beat_t b);
      logic [31:0] s;
      pkt_beats.push_back(eff_data(b));
      if (b.l || pkt_beats.size() == MAXW) begin
         s = '0;
         foreach (pkt_beats[i]) s = s + pkt_beats[i];
         exp_q.push_back(s);
         if (!b.l) exp_ovr = 1'b1;
         pkt_beats.delete();
      end
   endtask

   task automatic push(input logic [31:0] d, input logic [3:0] s, input logic l);
      beat_t b;
      b.d = d; b.s = s; b.l = l;
      stim_q.push_back(b);
   endtask

   // One clock: check outputs settled from the last edge, drive new inputs,
   // then account for the handshakes the next edge will perform.
   task automatic step(input int pv, input int pr);
      @(negedge clk);
      chk("tstrb", {28'd0, m_tstrb}, 32'hF);
      if (m_tvalid) begin
         chk("s_ready_in_send", {31'd0, s_tready}, 32'd0);
         chk("tlast", {31'd0, m_tlast}, 32'd1);
      end
      if (stalled) begin
         chk("hold_valid", {31'd0, m_tvalid}, 32'd1);
         chk("hold_data", m_tdata, held);
      end
      chk("pkt_count", {16'd0, pcnt}, {16'd0, delivered});
      chk("overrun", {31'd0, ovr}, {31'd0, exp_ovr});

      if (!s_pending) begin
         if (stim_q.size() > 0 && int'($urandom_range(99)) < pv) begin
            s_tdata  = stim_q[0].d;
            s_tstrb  = stim_q[0].s;
            s_tlast  = stim_q[0].l;
            s_tvalid = 1'b1;
         end else begin
            s_tvalid = 1'b0;
            s_tlast  = $urandom_range(1);
            s_tdata  = $urandom;
         end
      end
      m_tready = (int'($urandom_range(99)) < pr);

      if (s_tvalid && s_tready) begin
         model_beat(stim_q.pop_front());
         s_pending = 1'b0;
      end else begin
         s_pending = s_tvalid;
      end

      if (m_tvalid && m_tready) begin
         if (exp_q.size() == 0) chk("unexpected_out", 32'd1, 32'd0);
         else chk("sum", m_tdata, exp_q.pop_front());
         last_out  = m_tdata;
         delivered = delivered + 16'd1;
         n_out++;
         stalled = 1'b0;
      end else begin
         stalled = m_tvalid;
         held    = m_tdata;
      end
   endtask

   task automatic drain(input int pv, input int pr, input int budget);
      bit done;
      done = 0;
      for (int i = 0; i < budget; i++) begin
         if (stim_q.size() == 0 && exp_q.size() == 0 && !s_pending && !m_tvalid) begin
            done = 1;
            break;
         end
         step(pv, pr);
      end
      if (!done) chk("drain_timeout", 32'd0, 32'd1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst       = 1'b1;
      s_tvalid  = 1'b0;
      m_tready  = 1'b0;
      s_pending = 1'b0;
      stalled   = 1'b0;
      stim_q.delete();
      exp_q.delete();
      pkt_beats.delete();
      exp_ovr   = 1'b0;
      delivered = '0;
      n_out     = 0;
      repeat (2) @(negedge clk);
      chk("rst_s_ready", {31'd0, s_tready}, 32'd0);
      chk("rst_m_valid", {31'd0, m_tvalid}, 32'd0);
      chk("rst_m_data",  m_tdata, 32'd0);
      chk("rst_m_last",  {31'd0, m_tlast}, 32'd0);
      chk("rst_overrun", {31'd0, ovr}, 32'd0);
      chk("rst_count",   {16'd0, pcnt}, 32'd0);
      rst = 1'b0;
   endtask

   initial begin
      logic [31:0] exp_strb;
      int          len;
      do_reset();

      // Four-beat packet.
      push(32'd1, 4'hF, 0); push(32'd2, 4'hF, 0); push(32'd3, 4'hF, 0); push(32'd4, 4'hF, 1);
      drain(100, 100, 200);
      chk("tp_sum4", last_out, 32'h0000000A);
      chk("tp_cnt1", {16'd0, pcnt}, 32'd1);
      chk("tp_ovr0", {31'd0, ovr}, 32'd0);

      // Modulo wrap.
      push(32'hFFFFFFFF, 4'hF, 0); push(32'h2, 4'hF, 1);
      drain(100, 100, 200);
      chk("tp_wrap", last_out, 32'h00000001);

      // Forced termination at 80 beats, then a fresh one-beat packet.
      for (int i = 0; i < MAXW; i++) push(32'h1, 4'hF, 0);
      drain(100, 100, 500);
      chk("tp_forced", last_out, 32'h50);
      chk("tp_ovr1", {31'd0, ovr}, 32'd1);
      push(32'h7, 4'hF, 1);
      drain(100, 100, 200);
      chk("tp_after_forced", last_out, 32'h7);

      // Back-pressure: five stalled cycles, handshake on the sixth.
      push(32'h9, 4'hF, 1);
      step(100, 0);
      for (int i = 0; i < 5; i++) begin
         step(100, 0);
         chk("stall_valid", {31'd0, m_tvalid}, 32'd1);
         chk("stall_s_ready", {31'd0, s_tready}, 32'd0);
      end
      step(100, 100);
      chk("stall_release", {31'd0, m_tready & m_tvalid}, 32'd1);
      step(0, 100);
      chk("ready_after_send", {31'd0, s_tready}, 32'd1);
      chk("stall_data", last_out, 32'h9);

      // Reset mid-packet discards the partial sum.
      push(32'd5, 4'hF, 0); push(32'd5, 4'hF, 0); push(32'd5, 4'hF, 0);
      for (int i = 0; i < 3; i++) step(100, 100);
      do_reset();
      push(32'd5, 4'hF, 0); push(32'd5, 4'hF, 1);
      drain(100, 100, 200);
      chk("rst_mid_sum", last_out, 32'hA);
      chk("rst_mid_cnt", {16'd0, pcnt}, 32'd1);
      chk("rst_mid_nout", n_out, 32'd1);

      // Byte strobes.
      push(32'hAABBCCDD, 4'b0101, 1);
      drain(100, 100, 200);
`ifdef AXIS_PKT_SUM_STRB_MASK_EN
      exp_strb = 32'h00BB00DD;
`else
      exp_strb = 32'hAABBCCDD;
`endif
      chk("tp_strb", last_out, exp_strb);

      // Randomized packets, some long enough to be force-terminated.
      for (int p = 0; p < 40; p++) begin
         len = $urandom_range(100, 1);
         for (int i = 0; i < len; i++)
            push(($urandom_range(3) == 0) ? 32'hFFFFFFF0 + $urandom_range(15) : $urandom,
                 4'($urandom), (i == len - 1));
      end
      drain(70, 60, 30000);
      chk("rand_count", {16'd0, pcnt}, {16'd0, delivered});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
